// File: rtl/fir_mac_pipe_if.sv
// Beat, coefficient-load and result signals of the FIR MAC pipeline.
interface fir_mac_pipe_if #(
    parameter int unsigned TAPS  = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned OUT_W = 16
);
    localparam int unsigned LOG_T = $clog2(TAPS);
    localparam int unsigned ACC_W = DW + CW + LOG_T;

    logic                     in_valid;
    logic [TAPS*DW-1:0]       samples_flat;
    logic                     coef_we;
    logic [LOG_T-1:0]         coef_addr;
    logic signed [CW-1:0]     coef_data;
    logic                     coef_swap;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  y_full;
    logic signed [OUT_W-1:0]  y_out;
    logic                     sat_flag;

    modport master (
        output in_valid, samples_flat, coef_we, coef_addr, coef_data, coef_swap,
        input  out_valid, y_full, y_out, sat_flag
    );

    modport slave (
        input  in_valid, samples_flat, coef_we, coef_addr, coef_data, coef_swap,
        output out_valid, y_full, y_out, sat_flag
    );
endinterface

// File: rtl/fir_mac_pipe.sv
// Pipelined FIR multiply-accumulate: per-lane products against a double-buffered
// coefficient bank, registered adder tree, then round/shift/saturate.
module fir_mac_pipe #(
    parameter int unsigned TAPS      = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned CW        = 16,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned OUT_SHIFT = 15
) (
    input logic           clk,
    input logic           reset,
    fir_mac_pipe_if.slave bus
);
    localparam int unsigned LOG_T = $clog2(TAPS);
    localparam int unsigned PW    = DW + CW;
    localparam int unsigned ACC_W = PW + LOG_T;
    localparam int unsigned LAT   = LOG_T + 2;

    localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [CW-1:0]    shadow_q [TAPS];
    logic signed [CW-1:0]    active_q [TAPS];
    logic signed [PW-1:0]    prod_q   [TAPS];
    // Heap-ordered tree: node k sums nodes 2k and 2k+1; nodes >= TAPS/2 sum products.
    logic signed [ACC_W-1:0] tree_q   [1:TAPS-1];
    logic [LAT-1:0]          valid_q;
    logic signed [ACC_W-1:0] y_full_q;
    logic signed [OUT_W-1:0] y_out_q;
    logic                    sat_q;

    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   rnd_shift;
    logic signed [OUT_W-1:0] y_out_d;
    logic                    sat_d;

    // Coefficient banks; nonblocking update makes a same-cycle swap copy pre-write shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (bus.coef_swap) begin
                for (int i = 0; i < TAPS; i++) active_q[i] <= shadow_q[i];
            end
            if (bus.coef_we) shadow_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Stage P: lane products, always running; validity is tracked separately.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TAPS; i++) begin
            if (reset) prod_q[i] <= '0;
            else prod_q[i] <= PW'($signed(bus.samples_flat[i*DW +: DW])) * PW'(active_q[i]);
        end
    end

    // Adder tree, one register per level, all sums at full ACC_W width.
    always_ff @(posedge clk) begin
        for (int k = 1; k < TAPS / 2; k++) begin
            if (reset) tree_q[k] <= '0;
            else tree_q[k] <= tree_q[2*k] + tree_q[2*k+1];
        end
        for (int k = TAPS / 2; k < TAPS; k++) begin
            if (reset) tree_q[k] <= '0;
            else tree_q[k] <= ACC_W'(prod_q[2*k-TAPS]) + ACC_W'(prod_q[2*k-TAPS+1]);
        end
    end

    // Round half toward +inf, shift, then clip to the output range.
    always_comb begin
        rnd_sum   = {tree_q[1][ACC_W-1], tree_q[1]} + RND;
        rnd_shift = rnd_sum >>> OUT_SHIFT;
        y_out_d   = rnd_shift[OUT_W-1:0];
        sat_d     = 1'b0;
        if (rnd_shift > OUT_MAX) begin
            y_out_d = OUT_MAX[OUT_W-1:0];
            sat_d   = 1'b1;
        end else if (rnd_shift < OUT_MIN) begin
            y_out_d = OUT_MIN[OUT_W-1:0];
            sat_d   = 1'b1;
        end
    end

    // Stage R: output registers, with y_full re-registered to align with y_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_full_q <= '0;
            y_out_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            y_full_q <= tree_q[1];
            y_out_q  <= y_out_d;
            sat_q    <= sat_d;
        end
    end

    // Valid shift register matching the data path depth.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else valid_q <= {valid_q[LAT-2:0], bus.in_valid};
    end

    assign bus.out_valid = valid_q[LAT-1];
    assign bus.y_full    = y_full_q;
    assign bus.y_out     = y_out_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_fir_mac_pipe.sv
// Scoreboard bench for fir_mac_pipe at default parameters.
module tb_fir_mac_pipe;
    localparam int unsigned TAPS  = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned ACC_W = 36;

    typedef struct packed {
        logic [ACC_W-1:0] full;
        logic [15:0]      out;
        logic             sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [TAPS*DW-1:0] lanes;
    logic [5:0] exp_v = '0;
    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    fir_mac_pipe_if #(.TAPS(16), .DW(16), .CW(16), .OUT_W(16)) bus ();

    fir_mac_pipe #(
        .TAPS(16), .DW(16), .CW(16), .OUT_W(16), .OUT_SHIFT(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected out_valid: in_valid delayed by the six-cycle latency, flushed by reset.
    always @(posedge clk) begin
        exp_v <= reset ? 6'b0 : {exp_v[4:0], bus.in_valid};
    end

    // Monitor: timing check every cycle, value check for each presented result.
    always @(negedge clk) begin
        exp_t got, want;
        n_vec++;
        if (bus.out_valid !== exp_v[5]) begin
            n_err++;
            $display("FAIL out_valid_timing t=%0t got=%b want=%b", $time, bus.out_valid, exp_v[5]);
        end
        if (bus.out_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result t=%0t got y_full=%h y_out=%h", $time,
                         bus.y_full, bus.y_out);
            end else begin
                want = exp_q.pop_front();
                got  = {bus.y_full, bus.y_out, bus.sat_flag};
                if (got !== want) begin
                    n_err++;
                    $display("FAIL result t=%0t got y_full=%h y_out=%h sat=%b want y_full=%h y_out=%h sat=%b",
                             $time, got.full, got.out, got.sat, want.full, want.out, want.sat);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic push(input logic [ACC_W-1:0] f, input logic [15:0] o, input logic s);
        exp_q.push_back('{full: f, out: o, sat: s});
    endtask

    // One clock of stimulus; strobes drop again afterwards.
    task automatic cyc(input logic v, input logic we, input logic [3:0] a, input logic [15:0] d,
                       input logic sw);
        bus.in_valid     = v;
        bus.samples_flat = lanes;
        bus.coef_we      = we;
        bus.coef_addr    = a;
        bus.coef_data    = d;
        bus.coef_swap    = sw;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_swap = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic swap();
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    endtask

    task automatic beat();
        cyc(1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic set_all(input logic [15:0] d);
        for (int i = 0; i < TAPS; i++) wr(4'(i), d);
    endtask

    task automatic fill_lanes(input logic [15:0] d);
        for (int i = 0; i < TAPS; i++) lanes[i*DW +: DW] = d;
    endtask

    initial begin
        int pat [10] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        lanes            = '0;
        bus.in_valid     = 1'b0;
        bus.samples_flat = '0;
        bus.coef_we      = 1'b0;
        bus.coef_addr    = '0;
        bus.coef_data    = '0;
        bus.coef_swap    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_y_full", 64'(bus.y_full), 64'h0);
        chk("reset_y_out", 64'(bus.y_out), 64'h0);
        chk("reset_sat", 64'(bus.sat_flag), 64'h0);

        // Impulse through lane 3.
        wr(4'd3, 16'h2000);
        swap();
        lanes = '0;
        lanes[3*DW +: DW] = 16'h4000;
        push(36'h008000000, 16'h1000, 1'b0);
        beat();
        idle(8);

        // Rounding, including the half-way cases on both signs.
        wr(4'd3, 16'h0000);
        wr(4'd0, 16'h4000);
        swap();
        lanes = '0;
        lanes[DW-1:0] = 16'h0001;
        push(36'h000004000, 16'h0001, 1'b0);
        beat();
        lanes[DW-1:0] = 16'h0003;
        push(36'h00000C000, 16'h0002, 1'b0);
        beat();
        wr(4'd0, 16'hC000);
        swap();
        lanes[DW-1:0] = 16'h0001;
        push(-36'sd16384, 16'h0000, 1'b0);
        beat();
        lanes[DW-1:0] = 16'h0003;
        push(-36'sd49152, 16'hFFFF, 1'b0);
        beat();
        idle(8);

        // Saturation both ways.
        set_all(16'h4000);
        swap();
        fill_lanes(16'h4000);
        push(36'h100000000, 16'h7FFF, 1'b1);
        beat();
        set_all(16'h7FFF);
        swap();
        fill_lanes(16'h8000);
        push(-36'sd17179344896, 16'h8000, 1'b1);
        beat();
        idle(8);

        // Swap boundary with a same-cycle shadow write.
        set_all(16'h0000);
        wr(4'd0, 16'h4000);
        swap();
        wr(4'd0, 16'h2000);
        lanes = '0;
        lanes[DW-1:0] = 16'h0100;
        for (int i = 0; i < 7; i++) begin
            if (i <= 3) push(36'h000400000, 16'h0080, 1'b0);
            else push(36'h000200000, 16'h0040, 1'b0);
            cyc(1'b1, i == 3, 4'd0, 16'h1000, i == 3);
        end
        swap();
        push(36'h000100000, 16'h0020, 1'b0);
        beat();
        idle(8);

        // Bubble pattern; active coeff0 is now 0x1000.
        for (int j = 0; j < 10; j++) begin
            if (pat[j] != 0) begin
                lanes[DW-1:0] = 16'(16'h0100 * (j + 1));
                push(36'((j + 1) << 20), 16'((j + 1) * 32), 1'b0);
                beat();
            end else begin
                idle(1);
            end
        end
        idle(10);

        // Reset with three beats in flight: they must vanish, and banks clear.
        lanes[DW-1:0] = 16'h0100;
        repeat (3) beat();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_y_full", 64'(bus.y_full), 64'h0);
        chk("post_reset_y_out", 64'(bus.y_out), 64'h0);
        chk("post_reset_sat", 64'(bus.sat_flag), 64'h0);
        fill_lanes(16'h7FFF);
        push(36'h0, 16'h0, 1'b0);
        beat();
        idle(10);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fir_mac_pipe.md
# fir_mac_pipe

Parametrised, fully pipelined multiply–accumulate engine for fixed-point FIR filtering. Each valid beat carries TAPS packed signed samples; the block multiplies them against an internally held, double-buffered coefficient bank, reduces the products through a registered adder tree, and emits both the full-precision sum and a rounded, saturated output sample. It is the successor to the fixed 16-tap MAC core. It adds coefficient loading, valid tracking, per-level tree pipelining and output scaling.

## Interface
- TAPS, 16, number of taps; power of two, 2..64
- DW, 16, sample width (signed)
- CW, 16, coefficient width (signed, Q1.(CW-1))
- OUT_W, 16, scaled output width (signed)
- OUT_SHIFT, 15, right shift applied to the sum before saturation; 1..ACC_W-OUT_W
- ACC_W (local), DW+CW+log2(TAPS), full-precision sum width (36 at defaults)
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  samples_flat holds a valid beat this cycle
- samples_flat  in  TAPS*DW  lane i = samples_flat[i*DW +: DW], signed
- coef_we  in  1  write coef_data into shadow bank at coef_addr
- coef_addr  in  log2(TAPS)  shadow coefficient index (lane)
- coef_data  in  CW  signed coefficient
- coef_swap  in  1  copy the whole shadow bank into the active bank
- out_valid  out  1  y_full/y_out/sat_flag are valid this cycle
- y_full  out  ACC_W  signed full-precision sum
- y_out  out  OUT_W  rounded, shifted, saturated sum
- sat_flag  out  1  y_out was clipped this beat

## Operation
- Stage P: prod[i] = lane i × active[i], signed, DW+CW bits, registered.
- Tree: log2(TAPS) registered levels. Each level adds adjacent pairs and is sign-extended to ACC_W, so no overflow is possible. The last level registers y_full.
- Stage R: r = y_full + 2^(OUT_SHIFT-1) in ACC_W+1 bits, then arithmetic shift right by OUT_SHIFT (round half toward +inf).
  - If r > 2^(OUT_W-1)-1: y_out = max positive, sat_flag = 1.
  - If r < -2^(OUT_W-1): y_out = min negative, sat_flag = 1.
  - Otherwise y_out = r and sat_flag = 0.
  - y_full is re-registered alongside y_out so both appear on the same out_valid cycle.
- Valid: a 1-bit shift register runs parallel to the data. The data path runs every cycle regardless of in_valid; out_valid alone qualifies outputs.
- Coefficients:
  - coef_we writes the shadow bank only.
  - coef_swap copies all shadow entries to the active bank at the edge.
  - A beat presented in the swap cycle uses the old active bank. The first beat using the new bank is the one in the following cycle.
  - Simultaneous coef_we and coef_swap: the swap copies the pre-write shadow contents, and the write lands in the shadow only.
  - Active-bank changes never alter beats already past stage P.
- No backpressure: one beat accepted per cycle, one result per cycle.

## Timing
- Latency L = log2(TAPS) + 2 cycles from the in_valid edge to the out_valid edge (6 at defaults). Throughput is 1 beat per cycle.
- Reset (synchronous, active-high):
  - Clears the valid pipeline, both coefficient banks, all product/tree registers, y_full, y_out and sat_flag to 0.
  - out_valid is 0 in the cycle after reset is sampled.
  - Beats in flight when reset asserts are discarded and never appear on out_valid.
- While reset is high, in_valid, coef_we and coef_swap are ignored.
- Bubbles: an in_valid gap of n cycles produces an out_valid gap of exactly n cycles, L later.
- Outputs hold their last-computed values while out_valid=0. These values are not guaranteed meaningful.

## Test plan
- Impulse (defaults):
  - Stimulus: load coeff3=0x2000, swap; one beat with lane3=0x4000, other lanes 0.
  - Response: out_valid exactly 6 cycles later, y_full=0x008000000, y_out=0x1000, sat_flag=0.
- Rounding:
  - lane0=0x0001, coeff0=0x4000 → y_full=0x4000, y_out=1.
  - coeff0=0xC000 → y_full=-16384, y_out=0.
- Saturation:
  - All lanes 0x4000, all coeffs 0x4000 → y_full=0x100000000, y_out=0x7FFF, sat_flag=1.
  - All lanes 0x8000, all coeffs 0x7FFF → y_full=-17179344896, y_out=0x8000, sat_flag=1.
- Swap boundary:
  - Stimulus: stream constant lane0=0x0100 with coeff0 active at 0x4000 and shadow at 0x2000; pulse coef_swap in cycle k; also write coeff0 in the same cycle as the swap.
  - Response: beats up to k give y_out=0x80 and beats from k+1 give 0x40; the same-cycle write does not reach the active bank until the next swap.
- Bubbles/back-to-back: random in_valid pattern (e.g. 1101001) → out_valid reproduces the identical pattern delayed by 6, with values matching a reference model.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle with 3 beats in flight.
  - Response: none of the 3 beats produce out_valid; outputs are 0; coefficients are 0, so a following beat gives y_full=0.
